line_buffer_ctrl: RTL
=====================

Name: line_buffer_ctrl

Overview:
- Sequences one image frame through the 3-row line buffer.
- Accepts pixels over a valid/ready handshake and pushes them into the buffer, keeping the buffer's internal column counter aligned.
- Injects a zero bottom-padding row when enabled.
- Tags each cycle where a complete 3x3 window is present at the buffer outputs with win_valid and the window centre coordinates, so the downstream window generator can shift and mask edges.

Parameters:
- IMG_W, 28, pixels per row; must equal the line buffer's IMG_W.
- IMG_H, 28, rows per frame; must be at least 3.
- PADDING, 1, 0 = valid-only windows; 1 = same-size output with a zero border.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; share it with the line buffer.
- start  in  1  frame start pulse; sampled in IDLE only.
- pix_data  in  8  source pixel.
- pix_valid  in  1  source has a pixel.
- pix_ready  out  1  controller accepts a pixel this cycle.
- lb_data  out  8  registered pixel to line buffer in_data.
- lb_valid  out  1  registered push to line buffer in_valid.
- win_valid  out  1  buffer outputs complete a 3x3 window this cycle.
- win_row  out  $clog2(IMG_H)  window centre row.
- win_col  out  $clog2(IMG_W)  window centre column.
- busy  out  1  frame in progress (state is not IDLE).
- done  out  1  one-cycle pulse after the last window.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-frame aborts immediately. The line buffer is reset by the same rst_n, so both column counters restart together.
- Accept condition: acc = pix_valid & pix_ready.
- pix_ready is 1 only in FILL and STREAM.
- Push counters:
  - ri is $clog2(IMG_H+1) bits; ci is $clog2(IMG_W) bits.
  - Both advance on every push (accepted pixel or flush zero).
  - ci wraps from IMG_W-1 to 0 and increments ri.
- Push register: on each push at cycle t, lb_valid=1 and lb_data=pixel at t+1. Flush pushes drive lb_data=0. lb_valid=0 otherwise.
- Window tagging, for a push at (ri,ci) at cycle t:
  - win_valid, win_row and win_col appear at t+2, aligned with the line buffer's registered outputs.
  - Implement as a 2-stage pipeline of {qualify, row, col}.
  - PADDING=0: qualify = ri>=2 & ci>=2; centre = (ri-1, ci-1); 676 windows per frame at the defaults.
  - PADDING=1: qualify = ri>=1; centre = (ri-1, ci); 784 windows per frame.
  - With PADDING=1, downstream zeroes the top, left and right taps using win_row==0, win_col==0 and win_col==IMG_W-1.
- FSM states: IDLE, FILL, STREAM, FLUSH, DRAIN.
  - IDLE: start=1 moves to FILL; pixels are not accepted.
  - FILL: pushes until the first qualifying row is reached (ri==2 for PADDING=0, ri==1 for PADDING=1), then moves to STREAM.
  - STREAM: on the push of (IMG_H-1, IMG_W-1), go to FLUSH if PADDING=1, else DRAIN.
  - FLUSH: pix_ready=0; pushes IMG_W zeros on consecutive cycles with ri==IMG_H (qualifying); after the last zero, go to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, pulses done for 1 cycle in the cycle the last win_valid is seen, then returns to IDLE with counters cleared.
- pix_valid gaps stall FILL and STREAM with no push. The pipeline still advances, so win_valid deasserts during the gap.
- start while busy=1 is ignored; start and reset together: reset wins.
- Every frame pushes exactly IMG_W*IMG_H pixels, plus IMG_W zeros when PADDING=1, so the line buffer column counter returns to 0 at frame end.

Optional Feature:
- Macro: LBCTRL_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 16 bits.
  - Counts cycles in FILL or STREAM with pix_valid=0.
  - Saturates at 0xFFFF.
  - Clears on reset and on start accepted in IDLE.
  - Holds its value after done.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package lb_pkg holds:
  - default IMG_W and IMG_H;
  - the ROW_W and COL_W width functions;
  - the FSM state enum;
  - FILL_ROWS(PADDING) constant.
- One sub-module, lb_pos_counter: parameterised column/row counter with enable, clear, wrap and last-position flag. It is used for ri/ci.

Test Plan:
- PADDING=0, 28x28 ramp pixels (value = (r*28+c)&0xFF), pix_valid always 1:
  - 784 accepts, 676 win_valid pulses.
  - First window is centre (1,1), 2 cycles after pixel (2,2) is accepted; last is centre (26,26).
  - done is exactly 1 pulse; the line buffer's centre tap at the first window equals pixel (1,2)'s value 30.
- PADDING=1, same stream:
  - 784 win_valid pulses, first centre (0,0) at pixel (1,0) + 2 cycles.
  - 28 FLUSH cycles with pix_ready=0 and lb_data=0, last centre (27,27), then done.
- pix_valid toggled 1/0 every cycle:
  - No pixel lost, window count unchanged, win_valid only in cycles following pushes.
  - With LBCTRL_STALL_CNT_EN, stall_cnt = 784.
- start pulsed during STREAM has no effect.
- rst_n asserted mid-row 10, then a full new frame: all outputs 0 during reset, and the second frame matches the ideal window sequence exactly.
- Back-to-back frames, start on the cycle after done: two identical 676-window sequences, and line buffer alignment is preserved.

Source files
------------

// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared widths, defaults and FSM states for the line buffer controller
package lb_pkg;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  // Row counter must also hold IMG_H while the bottom padding row is pushed
  function automatic int ROW_W(input int img_h);
    return $clog2(img_h + 1);
  endfunction

  function automatic int COL_W(input int img_w);
    return $clog2(img_w);
  endfunction

  // Rows pushed before the first window can be complete
  function automatic int FILL_ROWS(input int padding);
    return (padding != 0) ? 1 : 2;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN
  } lb_state_e;

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// rtl/line_buffer_ctrl_if.sv - source pixel valid/ready handshake
interface line_buffer_ctrl_if;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/lb_pos_counter.sv
// rtl/lb_pos_counter.sv - wrapping position counter with clear and last-position flag
module lb_pos_counter #(
  parameter int MAX = 27,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_d, cnt_q;

  assign cnt  = cnt_q;
  assign last = (cnt_q == W'(MAX));

  // Next count: clear wins, otherwise step and wrap at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - frame sequencer for the 3-row line buffer; LBCTRL_STALL_CNT_EN adds stall_cnt
module line_buffer_ctrl
  import lb_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int PADDING = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  line_buffer_ctrl_if.slave          pix,
  output logic [7:0]                 lb_data,
  output logic                       lb_valid,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       done
`ifdef LBCTRL_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int RW  = ROW_W(IMG_H);
  localparam int CW  = COL_W(IMG_W);
  localparam int WRW = $clog2(IMG_H);
  localparam int FR  = FILL_ROWS(PADDING);

  lb_state_e state_d, state_q;
  logic drain_d, drain_q, done_d, done_q;
  logic [7:0] lbd_d, lbd_q;
  logic lbv_d, lbv_q;
  logic s1_v_d, s1_v_q, s2_v_q;
  logic [WRW-1:0] s1_row_d, s1_row_q, s2_row_q;
  logic [CW-1:0]  s1_col_d, s1_col_q, s2_col_q;
  logic push, flush, ready, clr;
  logic [RW-1:0] ri;
  logic [CW-1:0] ci;
  logic ci_last, ri_last;

  // Column counter wraps per row; row counter stops one past the last real row when padding
  lb_pos_counter #(.MAX(IMG_W - 1), .W(CW)) u_ci (
    .clk(clk), .rst_n(rst_n), .en(push), .clr(clr), .cnt(ci), .last(ci_last)
  );
  lb_pos_counter #(.MAX(IMG_H - 1 + PADDING), .W(RW)) u_ri (
    .clk(clk), .rst_n(rst_n), .en(push & ci_last), .clr(clr), .cnt(ri), .last(ri_last)
  );

  assign pix.pix_ready = ready;
  assign lb_data   = lbd_q;
  assign lb_valid  = lbv_q;
  assign win_valid = s2_v_q;
  assign win_row   = s2_row_q;
  assign win_col   = s2_col_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  // Frame sequencing: accept, flush padding row, then drain the window pipeline
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    ready   = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FILL;
      ST_FILL: begin
        ready = 1'b1;
        push  = pix.pix_valid;
        if (push && ci_last && ri == RW'(FR - 1)) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        ready = 1'b1;
        push  = pix.pix_valid;
        if (push && ci_last && ri == RW'(IMG_H - 1))
          state_d = (PADDING != 0) ? ST_FLUSH : ST_DRAIN;
      end
      ST_FLUSH: begin
        push  = 1'b1;
        flush = 1'b1;
        if (ci_last && ri_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b0;
          clr     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Push register and window-qualify stage 1 (centre is one row/column behind the push)
  always_comb begin
    lbv_d    = push;
    lbd_d    = (push && !flush) ? pix.pix_data : 8'h00;
    s1_row_d = WRW'(ri - RW'(1));
    s1_col_d = ci;
    if (PADDING != 0) begin
      s1_v_d = push && (ri != '0);
    end else begin
      s1_v_d   = push && (ri >= RW'(2)) && (ci >= CW'(2));
      s1_col_d = ci - CW'(1);
    end
  end

  // State, push and two-stage window tag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      lbd_q    <= '0;
      lbv_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      s1_row_q <= '0;
      s1_col_q <= '0;
      s2_v_q   <= 1'b0;
      s2_row_q <= '0;
      s2_col_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      lbd_q    <= lbd_d;
      lbv_q    <= lbv_d;
      s1_v_q   <= s1_v_d;
      s1_row_q <= s1_row_d;
      s1_col_q <= s1_col_d;
      s2_v_q   <= s1_v_q;
      s2_row_q <= s1_row_q;
      s2_col_q <= s1_col_q;
    end
  end

`ifdef LBCTRL_STALL_CNT_EN
  logic [15:0] stall_d, stall_q;
  assign stall_cnt = stall_q;

  // Saturating count of accepting cycles with no source pixel
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start)
      stall_d = '0;
    else if ((state_q == ST_FILL || state_q == ST_STREAM) && !pix.pix_valid && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`endif

endmodule
